scoreboard_mc: RTL
==================

# scoreboard_mc

Parametrised multi-writeback register scoreboard for the out-of-order RV32IMF core. It tracks one busy bit and one producer tag per architectural register across the integer and float files. It sits between decode/dispatch and the functional units. Additions over the single-port generation:
- configurable register count, tag width, source count and writeback-port count;
- same-cycle CDB bypass of readiness;
- a one-cycle pipeline flush;
- a registered occupancy counter.

## Interface
- NUM_ARCH_REGS, 32, registers per file (int and float); power of two, ≥2
- TAG_W, 3, functional-unit tag width
- NUM_SRC, 3, source-operand lookup ports
- NUM_CDB, 2, writeback (CDB) ports
- Derived: IDX_W = $clog2(NUM_ARCH_REGS); CNT_W = $clog2(2*NUM_ARCH_REGS+1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- issue_valid  in  1  dispatch presents an instruction
- issue_rd_we  in  1  instruction writes a destination register
- issue_rd  in  IDX_W  destination index
- issue_rd_is_float  in  1  1 = float file, 0 = int file
- issue_fu_id  in  TAG_W  producing FU tag
- issue_ready  out  1  1 = no WAW hazard and no flush; the instruction may issue
- src_idx  in  NUM_SRC*IDX_W  packed source indices; port k is in slice k
- src_is_float  in  NUM_SRC  per-source file select
- src_ready  out  NUM_SRC  1 = operand available
- src_tag  out  NUM_SRC*TAG_W  producer tag of a busy source
- cdb_valid  in  NUM_CDB  per-port writeback valid
- cdb_rd  in  NUM_CDB*IDX_W  per-port written register
- cdb_rd_is_float  in  NUM_CDB  per-port file select
- cdb_fu_id  in  NUM_CDB*TAG_W  per-port source FU tag
- flush  in  1  discard all in-flight producers
- busy_count  out  CNT_W  number of busy registers, registered

## Operation
- **State:** busy[2*NUM_ARCH_REGS] and tag[2*NUM_ARCH_REGS][TAG_W]. Entry = {is_float, idx}. Int x0 (entry 0) is never busy; writes to it are ignored.
- **Issue acceptance:** issue_fire = issue_valid & issue_ready & issue_rd_we & not (int x0). On fire, the entry sets busy=1 and tag=issue_fu_id.
- **issue_ready:**
  - 0 when flush=1.
  - Otherwise 1 if issue_rd_we=0 or the target is int x0.
  - Otherwise ~busy_eff[target].
- **Clear match:** cdb port p clears entry e when cdb_valid[p], {cdb_rd_is_float[p], cdb_rd[p]} = e, and cdb_fu_id[p] = tag[e]. A stale tag (mismatch) is ignored.
- **Sources:** src_ready[k] = ~busy_eff[entry_k]. Int x0 is always ready with tag 0. src_tag[k] = tag[entry_k] (the value is don't-care when ready).
- **busy_eff:** busy minus any same-cycle matching clear when bypass is compiled in; otherwise busy.
- **Simultaneous events:**
  - Issue fire and matching CDB clear to the same entry: issue wins; busy stays 1 with the new tag.
  - Multiple CDB ports hitting the same entry: cleared if any port matches.
  - Different entries: all updates apply.
- **Flush:** at the edge all busy bits go to 0, all tags to 0, and busy_count to 0. Issue and CDB inputs in the flush cycle are ignored.
- **busy_count:** next value = busy_count + issue_set − clears_applied. It counts entries only:
  - A clear applied to an entry being re-issued counts 0 net.
  - Duplicate clears to one entry count once.
  - Invariant: busy_count equals the popcount of busy at all times.

## Timing
- **Reset** (rst_n=0, asynchronous): busy=0, tags=0, busy_count=0. The combinational outputs then read issue_ready=1 (with flush=0), src_ready all 1, and src_tag all 0.
- **Issue:** issue_ready, src_ready and src_tag are combinational from state and current inputs, with zero latency. A busy bit set by issue is visible the next cycle.
- **CDB clear:** with bypass, visible in the same cycle on issue_ready/src_ready; without bypass, visible the next cycle.
- **Handshake:** dispatch must hold the instruction while issue_ready=0. No backpressure to the CDB; every cdb_valid is consumed in its cycle.
- **Reset mid-operation:** all state is lost immediately, asynchronously. No outstanding tag is honoured afterwards.

## Configuration
- **SCOREBOARD_CDB_BYPASS_EN defined:** matching CDB clears forward combinationally into issue_ready and src_ready in the same cycle.
- **Undefined:** readiness reflects registered state only, giving one extra cycle of RAW/WAW stall per writeback. This removes the CDB-to-dispatch combinational path.

## Test plan
- **Reset, idle:** after rst_n release, src_ready=3'b111, issue_ready=1, busy_count=0.
- **Issue then read:** issue x5 with tag 2. Next cycle src_idx[0]=5 (int) → src_ready[0]=0, src_tag[0]=2, and issue to x5 → issue_ready=0. CDB port 1 with {x5, tag 2} → ready the same cycle with bypass, or the next cycle without; busy_count goes 1→0.
- **Stale tag:** f3 busy with tag 4; CDB {f3, tag 1} → f3 stays busy and busy_count is unchanged.
- **Simultaneous:**
  - Case A: int x7 busy with tag 1; in the same cycle, CDB clears x7 with tag 1 while an instruction issues to x7 with tag 3. Required response (with bypass): x7 busy, tag 3, busy_count unchanged.
  - Case B: two CDB ports clear x9 and f9 in one cycle → both freed and busy_count decreases by 2.
- **x0:** issue to x0 with issue_rd_we=1 → issue_ready=1, and busy_count stays 0. A CDB write to x0 has no effect.
- **Flush:** make 5 registers busy, then assert flush with a concurrent issue → issue_ready=0 that cycle. Next cycle all src_ready=1 and busy_count=0.

Source files
------------

// File: rtl/scoreboard_mc.sv
// scoreboard_mc: multi-writeback register scoreboard covering the int and float
// register files. Tracks one busy bit and one producer tag per entry {is_float, idx}.
// Optional feature: define SCOREBOARD_CDB_BYPASS_EN to forward same-cycle CDB
// clears into issue_ready/src_ready; otherwise readiness uses registered state only.
module scoreboard_mc #(
  parameter int unsigned NUM_ARCH_REGS = 32,
  parameter int unsigned TAG_W         = 3,
  parameter int unsigned NUM_SRC       = 3,
  parameter int unsigned NUM_CDB       = 2,
  localparam int unsigned IDX_W        = $clog2(NUM_ARCH_REGS),
  localparam int unsigned CNT_W        = $clog2(2 * NUM_ARCH_REGS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  input  logic                       issue_rd_we,
  input  logic [IDX_W-1:0]           issue_rd,
  input  logic                       issue_rd_is_float,
  input  logic [TAG_W-1:0]           issue_fu_id,
  output logic                       issue_ready,
  input  logic [NUM_SRC*IDX_W-1:0]   src_idx,
  input  logic [NUM_SRC-1:0]         src_is_float,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic [NUM_SRC*TAG_W-1:0]   src_tag,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*IDX_W-1:0]   cdb_rd,
  input  logic [NUM_CDB-1:0]         cdb_rd_is_float,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_fu_id,
  input  logic                       flush,
  output logic [CNT_W-1:0]           busy_count
);

  localparam int unsigned ENT_W   = IDX_W + 1;
  localparam int unsigned NUM_ENT = 2 * NUM_ARCH_REGS;

  logic [NUM_ENT-1:0] busy_q, busy_d;
  logic [TAG_W-1:0]   tag_q [NUM_ENT];
  logic [TAG_W-1:0]   tag_d [NUM_ENT];
  logic [CNT_W-1:0]   busy_count_q, busy_count_d;

  logic [NUM_ENT-1:0] clear_hit;
  logic [NUM_ENT-1:0] busy_eff;
  logic [CNT_W-1:0]   clr_cnt;
  logic [ENT_W-1:0]   iss_ent;
  logic               iss_is_x0;
  logic               issue_fire;
  logic [ENT_W-1:0]   cdb_ent [NUM_CDB];
  logic [ENT_W-1:0]   src_ent [NUM_SRC];

  assign iss_ent   = {issue_rd_is_float, issue_rd};
  assign iss_is_x0 = (iss_ent == '0);

  // Form the scoreboard entry addressed by each CDB port
  always_comb begin
    cdb_ent = '{default: '0};
    for (int unsigned p = 0; p < NUM_CDB; p++) begin
      cdb_ent[p] = {cdb_rd_is_float[p], cdb_rd[p*IDX_W +: IDX_W]};
    end
  end

  // A clear applies only to a busy entry whose current tag matches; duplicates merge
  always_comb begin
    clear_hit = '0;
    for (int unsigned p = 0; p < NUM_CDB; p++) begin
      if (cdb_valid[p] && busy_q[cdb_ent[p]] &&
          (tag_q[cdb_ent[p]] == cdb_fu_id[p*TAG_W +: TAG_W])) begin
        clear_hit[cdb_ent[p]] = 1'b1;
      end
    end
  end

  // Number of distinct entries freed this cycle
  always_comb begin
    clr_cnt = '0;
    for (int unsigned e = 0; e < NUM_ENT; e++) begin
      clr_cnt = clr_cnt + CNT_W'(clear_hit[e]);
    end
  end

  // Busy view used for readiness: optionally hides same-cycle clears
  always_comb begin
`ifdef SCOREBOARD_CDB_BYPASS_EN
    busy_eff = busy_q & ~clear_hit;
`else
    busy_eff = busy_q;
`endif
  end

  // WAW check for dispatch; blocked entirely during flush
  always_comb begin
    issue_ready = 1'b0;
    if (flush) begin
      issue_ready = 1'b0;
    end else if (!issue_rd_we || iss_is_x0) begin
      issue_ready = 1'b1;
    end else begin
      issue_ready = ~busy_eff[iss_ent];
    end
  end

  assign issue_fire = issue_valid & issue_ready & issue_rd_we & ~iss_is_x0;

  // Source operand readiness and producer tag lookup
  always_comb begin
    src_ready = '0;
    src_tag   = '0;
    src_ent   = '{default: '0};
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      src_ent[k]                = {src_is_float[k], src_idx[k*IDX_W +: IDX_W]};
      src_ready[k]              = ~busy_eff[src_ent[k]];
      src_tag[k*TAG_W +: TAG_W] = (src_ent[k] == '0) ? '0 : tag_q[src_ent[k]];
    end
  end

  // Next state: clears first, then issue overrides; flush wipes everything
  always_comb begin
    busy_d       = busy_q & ~clear_hit;
    tag_d        = tag_q;
    busy_count_d = busy_count_q - clr_cnt;
    if (issue_fire) begin
      busy_d[iss_ent] = 1'b1;
      tag_d[iss_ent]  = issue_fu_id;
      busy_count_d    = busy_count_d + CNT_W'(1);
    end
    if (flush) begin
      busy_d       = '0;
      tag_d        = '{default: '0};
      busy_count_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      tag_q        <= '{default: '0};
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      tag_q        <= tag_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

endmodule
